control_notas: RTL and testbench
================================

Name: control_notas

Overview:
- Controller between the key inputs (teclas) and the music box's frequency divider.
- Synchronizes and debounces the 7 keys and arbitrates simultaneous presses by fixed priority.
- Sequences the divider: loads the selected note's half-period over a load/ack handshake, then enables tone output.
- Gates the tone off on release.

Parameters:
- DEB_CYCLES, 250000, clk cycles a key code must be stable before acceptance (10 ms at 25 MHz).
- MIN_HOLD_CYCLES, 2500000, minimum PLAY duration when NOTE_MIN_HOLD_EN is defined (100 ms).
- HALF_W, 16, width of the divider half-period value.

Ports:
- clk, input, 1, system clock, 25 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- teclas, input, 7, raw keys, active-high; [6]=Do ... [0]=Si.
- div_ack, input, 1, divider accepted div_half.
- div_half, output, HALF_W, half-period in clk cycles for the divider.
- div_load, output, 1, load request; held until acknowledged.
- div_en, output, 1, divider output enable (tone audible).
- nota_activa, output, 3, code of the note loaded/playing: 0 = none, 1 = Do ... 7 = Si.
- busy, output, 1, high in LOAD.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; synchronizer, debounce counter, stable code and hold counter cleared; FSM in IDLE. Release is synchronous to clk.
- Synchronizer: 2 flops per key bit.
- Priority encode of the synchronized vector gives the candidate code:
  - the highest set bit wins, teclas[6] -> 1 ... teclas[0] -> 7;
  - no bit set -> 0.
- Debounce:
  - counter increments while candidate equals the previous cycle's candidate;
  - any change clears it;
  - on reaching DEB_CYCLES-1, stable_code <= candidate;
  - the counter saturates, with no wrap.
- Half-period table (25 MHz): 1:47778, 2:42566, 3:37921, 4:35793, 5:31888, 6:28409, 7:25310.
- FSM states: IDLE, LOAD, PLAY.
- IDLE:
  - div_en=0, div_load=0, nota_activa=0;
  - when stable_code != 0, go to LOAD next cycle, latching the code and div_half from the table.
- LOAD:
  - div_load=1 and busy=1; div_half and nota_activa are stable;
  - div_en keeps its previous value (stays 1 on a note change, so the old tone continues until ack);
  - on a cycle with div_ack=1, go to PLAY; div_load falls next cycle.
  - If stable_code changes during LOAD: the current handshake completes with the latched value; the change is handled in PLAY.
- PLAY:
  - div_en=1;
  - stable_code == 0 -> IDLE; div_en and nota_activa fall next cycle;
  - stable_code nonzero and != latched code -> LOAD with the new code/div_half;
  - otherwise stay.
- Latency from raw key edge to div_load rising: 2 (synchronizer) + DEB_CYCLES + 1 cycles.
- div_ack outside LOAD is ignored.
- Reset mid-handshake aborts the load: div_load drops immediately.

Optional Feature:
- Macro: NOTE_MIN_HOLD_EN.
- Defined:
  - a hold counter clears on every entry to PLAY;
  - PLAY exits (release or note change) are blocked until the counter reaches MIN_HOLD_CYCLES-1;
  - after that, the current stable_code is evaluated normally, so short taps still sound for the minimum time.
- Undefined: no hold counter; PLAY exits as soon as stable_code allows.

Test Plan (DEB_CYCLES=4, MIN_HOLD_CYCLES=8):
- Reset:
  - stimulus: rst_n=0 with teclas=7'b1000000 and div_ack=1;
  - response: div_half=0, div_load=0, div_en=0, nota_activa=0; nothing happens until rst_n=1.
- Single key:
  - stimulus: teclas=7'b0000100 held; div_ack pulsed 3 cycles after div_load rises;
  - response: div_load rises 7 cycles after the key edge with div_half=31888 and nota_activa=5; then div_en=1.
- Bounce:
  - stimulus: teclas toggles 7'b0001000/0 every 2 cycles for 20 cycles, then holds 7'b0001000;
  - response: no div_load during bouncing; a single load of 35793 after stable.
- Simultaneous keys:
  - stimulus: teclas=7'b0100001;
  - response: nota_activa=2, div_half=42566.
- Note change and release:
  - stimulus: from PLAY on 1 (47778), switch to 7'b0000001, then release;
  - response: div_en stays 1 through a LOAD of 25310; then div_en=0 and nota_activa=0 one cycle after stable_code becomes 0.
- Hold feature:
  - stimulus: with NOTE_MIN_HOLD_EN defined, release 2 cycles after entering PLAY;
  - response: div_en remains 1 for 8 PLAY cycles, then falls;
  - without the macro: falls immediately after the debounced release.

Source files
------------

// File: rtl/control_notas.sv
// rtl/control_notas.sv - key sync/debounce/priority and divider load sequencing
// Optional: define NOTE_MIN_HOLD_EN to enforce a minimum PLAY duration.
module control_notas #(
    parameter int DEB_CYCLES      = 250000,
    parameter int MIN_HOLD_CYCLES = 2500000,
    parameter int HALF_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        teclas,
    input  logic              div_ack,
    output logic [HALF_W-1:0] div_half,
    output logic              div_load,
    output logic              div_en,
    output logic [2:0]        nota_activa,
    output logic              busy
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    logic [6:0]        r_sync1, r_sync2;
    logic [2:0]        r_prev_cand, r_stable, r_code;
    logic [DW-1:0]     r_deb_cnt;
    logic [HALF_W-1:0] r_half;
    logic              r_en;
    state_t            r_state, w_state_next;

    logic [2:0]        w_cand;
    logic [DW-1:0]     w_deb_next;
    logic              w_latch, w_en_next, w_exit_ok;

    function automatic logic [HALF_W-1:0] f_half(input logic [2:0] code);
        case (code)
            3'd1:    f_half = HALF_W'(47778);
            3'd2:    f_half = HALF_W'(42566);
            3'd3:    f_half = HALF_W'(37921);
            3'd4:    f_half = HALF_W'(35793);
            3'd5:    f_half = HALF_W'(31888);
            3'd6:    f_half = HALF_W'(28409);
            3'd7:    f_half = HALF_W'(25310);
            default: f_half = '0;
        endcase
    endfunction

    // Ascending scan lets the highest set bit (Do) override lower keys.
    always_comb begin
        w_cand = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (r_sync2[i]) w_cand = 3'(7 - i);
        end
    end

    always_comb begin
        if (w_cand != r_prev_cand)   w_deb_next = '0;
        else if (r_deb_cnt == DEB_LAST) w_deb_next = r_deb_cnt;
        else                         w_deb_next = r_deb_cnt + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev_cand <= '0;
            r_deb_cnt   <= '0;
            r_stable    <= '0;
        end else begin
            r_sync1     <= teclas;
            r_sync2     <= r_sync1;
            r_prev_cand <= w_cand;
            r_deb_cnt   <= w_deb_next;
            if (w_deb_next == DEB_LAST) r_stable <= w_cand;
        end
    end

`ifdef NOTE_MIN_HOLD_EN
    localparam int HW = (MIN_HOLD_CYCLES > 1) ? $clog2(MIN_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD_CYCLES - 1);
    logic [HW-1:0] r_hold;

    // Held at zero outside PLAY, so each PLAY entry starts a fresh hold window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_hold <= '0;
        else if (r_state != S_PLAY)   r_hold <= '0;
        else if (r_hold != HOLD_LAST) r_hold <= r_hold + HW'(1);
    end

    assign w_exit_ok = (r_hold == HOLD_LAST);
`else
    assign w_exit_ok = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_en_next    = r_en;
        case (r_state)
            S_IDLE: begin
                w_en_next = 1'b0;
                if (r_stable != 3'd0) begin
                    w_state_next = S_LOAD;
                    w_latch      = 1'b1;
                end
            end
            S_LOAD: begin
                if (div_ack) begin
                    w_state_next = S_PLAY;
                    w_en_next    = 1'b1;
                end
            end
            S_PLAY: begin
                w_en_next = 1'b1;
                if (w_exit_ok) begin
                    if (r_stable == 3'd0) begin
                        w_state_next = S_IDLE;
                        w_en_next    = 1'b0;
                    end else if (r_stable != r_code) begin
                        w_state_next = S_LOAD;
                        w_latch      = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_half  <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_en    <= w_en_next;
            if (w_latch) begin
                r_code <= r_stable;
                r_half <= f_half(r_stable);
            end else if (w_state_next == S_IDLE) begin
                r_code <= '0;
            end
        end
    end

    assign div_half    = r_half;
    assign div_load    = (r_state == S_LOAD);
    assign busy        = (r_state == S_LOAD);
    assign div_en      = r_en;
    assign nota_activa = r_code;

endmodule

// File: tb/tb_control_notas.sv
// tb/tb_control_notas.sv - table-driven and randomized checks for control_notas
module tb_control_notas;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
`ifdef NOTE_MIN_HOLD_EN
    localparam int HOLD_EN = 1;
    localparam int SEG_MIN = 16;
`else
    localparam int HOLD_EN = 0;
    localparam int SEG_MIN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  teclas = '0;
    logic        man_ack = 1'b0;
    logic        auto_ack = 1'b0;
    logic        auto_mode = 1'b0;
    logic        div_ack;
    logic [15:0] div_half;
    logic        div_load, div_en, busy;
    logic [2:0]  nota_activa;

    assign div_ack = auto_mode ? auto_ack : man_ack;

    control_notas #(.DEB_CYCLES(DEB), .MIN_HOLD_CYCLES(HOLD), .HALF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .teclas(teclas), .div_ack(div_ack),
        .div_half(div_half), .div_load(div_load), .div_en(div_en),
        .nota_activa(nota_activa), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the highest pressed key (Do = bit 6) wins; code 1 = Do ... 7 = Si.
    function automatic int ref_code(input logic [6:0] v);
        for (int i = 6; i >= 0; i--) if (v[i]) return 7 - i;
        return 0;
    endfunction

    function automatic int ref_half(input int code);
        int tab [8] = '{0, 47778, 42566, 37921, 35793, 31888, 28409, 25310};
        return tab[code];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; teclas = '0; man_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_load(output int cyc, output bit ok);
        ok = 0; cyc = 0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            @(negedge clk);
            if (div_load) begin ok = 1; cyc = i; end
        end
    endtask

    task automatic wait_en_low(output int cyc, output bit ok);
        ok = 0; cyc = 0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            @(negedge clk);
            if (!div_en) begin ok = 1; cyc = i; end
        end
    endtask

    task automatic ack_once();
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  keys;
        logic [2:0]  code;
        logic [15:0] half;
    } vec_t;

    // Random-phase scoreboard: expected load codes and whether the tone was already on.
    int exp_q[$];
    bit exp_en_q[$];
    int loads_seen = 0;
    int ack_dly = 0;
    logic prev_load = 1'b0;

    always @(negedge clk) begin
        if (auto_mode) begin
            if (div_load && !prev_load) begin
                loads_seen++;
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_load", 32'(nota_activa), 0);
                end else begin
                    int c;
                    bit e;
                    c = exp_q.pop_front();
                    e = exp_en_q.pop_front();
                    chk("rand_code", 32'(nota_activa), 32'(c));
                    chk("rand_half", 32'(div_half), 32'(ref_half(c)));
                    chk("rand_en_at_load", 32'(div_en), 32'(e));
                end
                ack_dly = $urandom_range(0, 3);
            end
            if (div_load) begin
                if (ack_dly == 0) auto_ack = 1'b1;
                else begin auto_ack = 1'b0; ack_dly--; end
            end else begin
                auto_ack = 1'b0;
            end
            prev_load = div_load;
        end else begin
            auto_ack  = 1'b0;
            prev_load = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab [10];
        int cyc, n, seen, last, exp_loads;
        bit ok, done;

        tab[0] = '{7'b1000000, 3'd1, 16'd47778};
        tab[1] = '{7'b0100000, 3'd2, 16'd42566};
        tab[2] = '{7'b0010000, 3'd3, 16'd37921};
        tab[3] = '{7'b0001000, 3'd4, 16'd35793};
        tab[4] = '{7'b0000100, 3'd5, 16'd31888};
        tab[5] = '{7'b0000010, 3'd6, 16'd28409};
        tab[6] = '{7'b0000001, 3'd7, 16'd25310};
        tab[7] = '{7'b0100001, 3'd2, 16'd42566};
        tab[8] = '{7'b1111111, 3'd1, 16'd47778};
        tab[9] = '{7'b0000011, 3'd6, 16'd28409};

        // Reset holds everything quiet despite a pressed key and a pending ack.
        rst_n = 1'b0; teclas = 7'b1000000; man_ack = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_half", 32'(div_half), 0);
        chk("rst_load", 32'(div_load), 0);
        chk("rst_en", 32'(div_en), 0);
        chk("rst_nota", 32'(nota_activa), 0);
        chk("rst_busy", 32'(busy), 0);
        teclas = '0; man_ack = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // Ack outside LOAD has no effect.
        man_ack = 1'b1;
        repeat (3) @(negedge clk);
        man_ack = 1'b0;
        chk("idle_ack_en", 32'(div_en), 0);
        chk("idle_ack_load", 32'(div_load), 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            teclas = tab[i].keys;
            wait_load(cyc, ok);
            chk("tab_load_seen", 32'(ok), 1);
            chk("tab_latency", 32'(cyc), 7);
            chk("tab_half", 32'(div_half), 32'(tab[i].half));
            chk("tab_code", 32'(nota_activa), 32'(tab[i].code));
            chk("tab_busy", 32'(busy), 1);
            chk("tab_en_in_load", 32'(div_en), 0);
            repeat (i % 4) @(negedge clk);
            chk("tab_load_held", 32'(div_load), 1);
            ack_once();
            chk("tab_en_play", 32'(div_en), 1);
            chk("tab_load_fell", 32'(div_load), 0);
            teclas = '0;
            wait_en_low(cyc, ok);
            chk("tab_release_seen", 32'(ok), 1);
            chk("tab_release_nota", 32'(nota_activa), 0);
        end

        // Bounce: no load while toggling, then exactly one load.
        do_reset();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            teclas = (k % 2 == 0) ? 7'b0001000 : 7'b0000000;
            repeat (2) begin
                @(negedge clk);
                if (div_load) seen++;
            end
        end
        chk("bounce_no_load", 32'(seen), 0);
        teclas = 7'b0001000;
        wait_load(cyc, ok);
        chk("bounce_load_seen", 32'(ok), 1);
        chk("bounce_half", 32'(div_half), 35793);
        chk("bounce_code", 32'(nota_activa), 4);
        ack_once();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (div_load) seen++;
        end
        chk("bounce_single_load", 32'(seen), 0);

        // Note change keeps the old tone on during the new load, then release.
        do_reset();
        teclas = 7'b1000000;
        wait_load(cyc, ok);
        chk("chg_first_half", 32'(div_half), 47778);
        ack_once();
        repeat (10) @(negedge clk);
        teclas = 7'b0000001;
        wait_load(cyc, ok);
        chk("chg_load_seen", 32'(ok), 1);
        chk("chg_latency", 32'(cyc), 7);
        chk("chg_half", 32'(div_half), 25310);
        chk("chg_code", 32'(nota_activa), 7);
        chk("chg_en_in_load", 32'(div_en), 1);
        repeat (2) @(negedge clk);
        chk("chg_en_held", 32'(div_en), 1);
        ack_once();
        chk("chg_en_play", 32'(div_en), 1);
        repeat (10) @(negedge clk);
        teclas = '0;
        wait_en_low(cyc, ok);
        chk("chg_release_latency", 32'(cyc), 7);
        chk("chg_release_nota", 32'(nota_activa), 0);

        // Release right at PLAY entry: tone lasts the debounce time or the minimum hold.
        do_reset();
        teclas = 7'b0000100;
        wait_load(cyc, ok);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        teclas = '0;
        n = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (div_en) n++;
            else done = 1;
            if (!done) @(negedge clk);
        end
        chk("hold_play_cycles", 32'(n), (HOLD_EN != 0) ? 32'(HOLD) : 32'(7));

        // Reset during a handshake drops the load request at once.
        do_reset();
        teclas = 7'b0000100;
        wait_load(cyc, ok);
        chk("abort_load_seen", 32'(ok), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_load", 32'(div_load), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_nota", 32'(nota_activa), 0);
        @(negedge clk);
        teclas = '0;
        rst_n = 1'b1;

        // Randomized segments checked against a dedup-of-codes scoreboard.
        do_reset();
        auto_mode = 1'b1;
        last = 0; exp_loads = 0;
        for (int s = 0; s < 40; s++) begin
            logic [6:0] v;
            int c;
            v = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) v = '0;
            c = ref_code(v);
            if (c != last) begin
                if (c != 0) begin
                    exp_q.push_back(c);
                    exp_en_q.push_back(last != 0);
                    exp_loads++;
                end
                last = c;
            end
            teclas = v;
            repeat ($urandom_range(SEG_MIN, SEG_MIN + 10)) @(negedge clk);
        end
        teclas = '0;
        repeat (30) @(negedge clk);
        auto_mode = 1'b0;
        chk("rand_pending", 32'(exp_q.size()), 0);
        chk("rand_load_count", 32'(loads_seen), 32'(exp_loads));
        chk("rand_final_en", 32'(div_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
